io_port_router: RTL and testbench
=================================

// Module: io_port_router
// PURPOSE
// Parametrised IO port controller: decodes CPU port space into NUM_SLOTS peripheral slots of 2^SLOT_BITS words.
// Adds a per-slot ready handshake with timeout/bus-error, and a per-slot registered/late read-data mode.
// Adds a built-in interrupt aggregator (pending/mask) at slot CTRL_SLOT.
// Sits between the CPU port bus and the peripherals (uart, gpio, pwm_led, spi_flash, gfx, ...).
// PARAMETERS
// BITS          16     data width
// ADDRESS_BITS  16     CPU port address width
// NUM_SLOTS     8      peripheral slots (1..BITS), slot s = addresses s<<SLOT_BITS ..
// SLOT_BITS     12     address bits passed to each peripheral
// LATE_MASK     8'h20  bit s=1: slot s drives read data already delayed one cycle (gfx style)
// CTRL_SLOT     10     slot index of internal control registers (must be >= NUM_SLOTS)
// TIMEOUT       15     max WAIT cycles before bus error (1..255)
// PORTS
// CLK            in   1                  clock
// RSTb           in   1                  reset, synchronous, active-low
// ADDRESS        in   ADDRESS_BITS       CPU port address, held stable until READY
// DATA_IN        in   BITS               CPU write data
// DATA_OUT       out  BITS               CPU read data, valid the cycle after READY
// memWR          in   1                  write request
// memRD          in   1                  read request
// READY          out  1                  access completes this cycle
// BUS_ERR        out  1                  access completed by timeout (qualifies READY)
// slot_addr      out  SLOT_BITS          ADDRESS[SLOT_BITS-1:0]
// slot_wdata     out  BITS               DATA_IN passthrough
// slot_wr        out  NUM_SLOTS          one-hot write strobe
// slot_rd        out  NUM_SLOTS          one-hot read strobe
// slot_rdata     in   NUM_SLOTS*BITS     flattened read data, slot s at [s*BITS +: BITS]
// slot_ready     in   NUM_SLOTS          peripheral accepts/completes access
// irq_in         in   NUM_SLOTS          level interrupt requests
// irq            out  1                  |(pending & mask)
// BEHAVIOUR
// - sel = ADDRESS[ADDRESS_BITS-1:SLOT_BITS]. Mapped if sel<NUM_SLOTS. Ctrl if sel==CTRL_SLOT. Otherwise unmapped.
// - memWR has priority: if both memWR and memRD are asserted, treat as a write, and slot_rd stays 0.
// - FSM IDLE/WAIT/ERR:
//   - IDLE, request to mapped sel: slot_wr/slot_rd[sel] asserted combinationally.
//     - slot_ready[sel]=1: READY=1 same cycle, stay IDLE.
//     - Else: go to WAIT with cnt=1.
//   - WAIT: strobe held and cnt increments each cycle.
//     - slot_ready[sel]: READY=1, go to IDLE.
//     - Else if cnt==TIMEOUT: go to ERR.
//   - ERR (1 cycle): strobes 0, READY=1, BUS_ERR=1, read data 0.
//     - Sets err_flag and captures err_addr<=ADDRESS.
//     - Then go to IDLE.
//   - Ctrl and unmapped accesses complete in IDLE with READY=1 and no strobes.
//     - Unmapped writes are dropped; unmapped reads return 0.
// - READY=0 and BUS_ERR=0 when no request is present.
// - Read path: on the READY cycle of a read, dout<=selected data and sel_q<=sel.
//   - DATA_OUT = LATE_MASK[sel_q] ? slot_rdata[sel_q] (live) : dout.
//   - Read latency is 1 cycle after READY.
// - Ctrl regs, indexed by ADDRESS[1:0]:
//   - 0 PENDING: read; write 1 to clear.
//   - 1 MASK: read/write.
//   - 2 ERR: bit0 err_flag; write 1 to clear.
//   - 3 ERR_ADDR: read-only.
// - pending[s] sets on a rising edge of irq_in[s] (registered prev). Set wins over a same-cycle clear.
// - irq is registered: irq <= |(pending_next & mask_next).
// - Reset: FSM IDLE, cnt=0, dout=0, sel_q=CTRL_SLOT, pending/mask/err_flag/err_addr=0, irq_prev=0.
//   - Reset outputs: DATA_OUT=0, irq=0, READY=0, BUS_ERR=0, strobes 0.
// - Reset mid-WAIT aborts the access with no READY and no error recorded.
// TESTING
// - Read slot 1 (0x1004), slot_ready=1, rdata1=0xBEEF -> READY same cycle, slot_rd=8'h02, DATA_OUT=0xBEEF next cycle.
// - Write slot 4, slot_ready low 3 cycles -> slot_wr[4] held 4 cycles, READY on 4th, BUS_ERR=0.
// - Read slot 3, slot_ready stuck low -> READY+BUS_ERR at cycle TIMEOUT+1, DATA_OUT=0, ERR_ADDR reads 0x3xxx, ERR=1.
// - Read slot 5 (LATE) -> DATA_OUT tracks live slot_rdata[5] the cycle after READY, not dout.
// - MASK=0x04, irq_in[2] 0->1 -> PENDING=0x04, irq=1; write 0x04 to PENDING with a new edge the same cycle -> stays set.
// - Read 0x9000 (unmapped) -> READY=1, DATA_OUT=0, no strobes; both memWR and memRD on slot 0 -> only slot_wr[0].

Source files
------------

// File: rtl/io_port_router.sv
// CPU port-space decoder: routes accesses to NUM_SLOTS peripheral slots with a ready/timeout
// handshake, per-slot late read data, and an internal interrupt/error register block.
module io_port_router #(
   parameter int                   BITS         = 16,
   parameter int                   ADDRESS_BITS = 16,
   parameter int                   NUM_SLOTS    = 8,
   parameter int                   SLOT_BITS    = 12,
   parameter logic [NUM_SLOTS-1:0] LATE_MASK    = 8'h20,
   parameter int                   CTRL_SLOT    = 10,
   parameter int                   TIMEOUT      = 15
) (
   input  logic                      CLK,
   input  logic                      RSTb,
   input  logic [ADDRESS_BITS-1:0]   ADDRESS,
   input  logic [BITS-1:0]           DATA_IN,
   output logic [BITS-1:0]           DATA_OUT,
   input  logic                      memWR,
   input  logic                      memRD,
   output logic                      READY,
   output logic                      BUS_ERR,
   output logic [SLOT_BITS-1:0]      slot_addr,
   output logic [BITS-1:0]           slot_wdata,
   output logic [NUM_SLOTS-1:0]      slot_wr,
   output logic [NUM_SLOTS-1:0]      slot_rd,
   input  logic [NUM_SLOTS*BITS-1:0] slot_rdata,
   input  logic [NUM_SLOTS-1:0]      slot_ready,
   input  logic [NUM_SLOTS-1:0]      irq_in,
   output logic                      irq
);
   localparam int SEL_W = ADDRESS_BITS - SLOT_BITS;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

   state_t                  r_state, w_next;
   logic [7:0]              r_cnt;
   logic [BITS-1:0]         r_dout;
   logic [SEL_W-1:0]        r_sel_q;
   logic [NUM_SLOTS-1:0]    r_pending, r_mask, r_irq_prev;
   logic                    r_err_flag, r_irq;
   logic [ADDRESS_BITS-1:0] r_err_addr;

   logic [SEL_W-1:0]        w_sel;
   logic                    w_mapped, w_ctrl, w_req, w_rd;
   logic [NUM_SLOTS-1:0]    w_dec;
   logic                    w_slot_rdy, w_late;
   logic [BITS-1:0]         w_slot_dat, w_late_dat, w_ctrl_dat;
   logic                    w_ready, w_bus_err;
   logic [NUM_SLOTS-1:0]    w_wr_stb, w_rd_stb;
   logic                    w_ctrl_wr;
   logic [NUM_SLOTS-1:0]    w_clr, w_rise, w_pend_nx, w_mask_nx;

   assign w_sel      = ADDRESS[ADDRESS_BITS-1:SLOT_BITS];
   assign w_mapped   = 32'(w_sel) < 32'(NUM_SLOTS);
   assign w_ctrl     = (w_sel == SEL_W'(CTRL_SLOT));
   assign w_req      = memWR | memRD;
   assign w_rd       = memRD & ~memWR;
   assign slot_addr  = ADDRESS[SLOT_BITS-1:0];
   assign slot_wdata = DATA_IN;

   // Slot muxes: one on the live address, one on the slot captured by the last read.
   always_comb begin
      w_dec      = '0;
      w_slot_rdy = 1'b0;
      w_slot_dat = '0;
      w_late     = 1'b0;
      w_late_dat = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (w_sel == SEL_W'(s)) begin
            w_dec[s]   = 1'b1;
            w_slot_rdy = slot_ready[s];
            w_slot_dat = slot_rdata[s*BITS +: BITS];
         end
         if (r_sel_q == SEL_W'(s)) begin
            w_late     = LATE_MASK[s];
            w_late_dat = slot_rdata[s*BITS +: BITS];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req && w_mapped && !w_slot_rdy) w_next = S_WAIT;
         S_WAIT:  if (!w_req || w_slot_rdy)             w_next = S_IDLE;
                  else if (r_cnt == 8'(TIMEOUT))        w_next = S_ERR;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even mid-access.
   always_comb begin
      w_ready   = 1'b0;
      w_bus_err = 1'b0;
      w_wr_stb  = '0;
      w_rd_stb  = '0;
      if (RSTb) begin
         case (r_state)
            S_IDLE: if (w_req) begin
               if (w_mapped) begin
                  w_wr_stb = {NUM_SLOTS{memWR}} & w_dec;
                  w_rd_stb = {NUM_SLOTS{w_rd}} & w_dec;
                  w_ready  = w_slot_rdy;
               end else begin
                  w_ready  = 1'b1;
               end
            end
            S_WAIT: if (w_req) begin
               w_wr_stb = {NUM_SLOTS{memWR}} & w_dec;
               w_rd_stb = {NUM_SLOTS{w_rd}} & w_dec;
               w_ready  = w_slot_rdy;
            end
            S_ERR: begin
               w_ready   = 1'b1;
               w_bus_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign READY   = w_ready;
   assign BUS_ERR = w_bus_err;
   assign slot_wr = w_wr_stb;
   assign slot_rd = w_rd_stb;

   always_ff @(posedge CLK) begin
      if (!RSTb)                  r_cnt <= '0;
      else if (w_next != S_WAIT)  r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      else                        r_cnt <= 8'd1;
   end

   always_comb begin
      case (ADDRESS[1:0])
         2'd0:    w_ctrl_dat = BITS'(r_pending);
         2'd1:    w_ctrl_dat = BITS'(r_mask);
         2'd2:    w_ctrl_dat = BITS'(r_err_flag);
         default: w_ctrl_dat = BITS'(r_err_addr);
      endcase
   end

   // A timed-out read parks sel_q on the ctrl slot so a late slot cannot leak live data.
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         r_dout  <= '0;
         r_sel_q <= SEL_W'(CTRL_SLOT);
      end else if (r_state == S_ERR) begin
         if (w_rd) begin
            r_dout  <= '0;
            r_sel_q <= SEL_W'(CTRL_SLOT);
         end
      end else if (w_ready && w_rd) begin
         r_sel_q <= w_sel;
         r_dout  <= w_mapped ? w_slot_dat : (w_ctrl ? w_ctrl_dat : '0);
      end
   end

   assign w_ctrl_wr = RSTb && (r_state == S_IDLE) && memWR && w_ctrl;
   assign w_clr     = (w_ctrl_wr && ADDRESS[1:0] == 2'd0) ? DATA_IN[NUM_SLOTS-1:0] : '0;
   assign w_rise    = irq_in & ~r_irq_prev;
   assign w_pend_nx = (r_pending & ~w_clr) | w_rise;
   assign w_mask_nx = (w_ctrl_wr && ADDRESS[1:0] == 2'd1) ? DATA_IN[NUM_SLOTS-1:0] : r_mask;

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         r_pending  <= '0;
         r_mask     <= '0;
         r_irq_prev <= '0;
         r_irq      <= 1'b0;
         r_err_flag <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_pending  <= w_pend_nx;
         r_mask     <= w_mask_nx;
         r_irq_prev <= irq_in;
         r_irq      <= |(w_pend_nx & w_mask_nx);
         if (r_state == S_ERR) begin
            r_err_flag <= 1'b1;
            r_err_addr <= ADDRESS;
         end else if (w_ctrl_wr && ADDRESS[1:0] == 2'd2 && DATA_IN[0]) begin
            r_err_flag <= 1'b0;
         end
      end
   end

   assign irq      = r_irq;
   assign DATA_OUT = w_late ? w_late_dat : r_dout;

endmodule

// File: tb/tb_io_port_router.sv
// Bench for io_port_router: directed scenarios plus randomized accesses checked against
// a transaction-level model of the slot map, handshake timing and control registers.
module tb_io_port_router;
   localparam int         NS   = 8;
   localparam int         TO   = 15;
   localparam int         CTRL = 10;
   localparam logic [7:0] LATE = 8'h20;

   logic          CLK, RSTb;
   logic [15:0]   ADDRESS, DATA_IN, DATA_OUT;
   logic          memWR, memRD, READY, BUS_ERR, irq;
   logic [11:0]   slot_addr;
   logic [15:0]   slot_wdata;
   logic [7:0]    slot_wr, slot_rd, slot_ready, irq_in;
   logic [127:0]  slot_rdata;

   logic [15:0]   m_rdata [NS];
   logic [7:0]    m_pend, m_mask;
   logic          m_err;
   logic [15:0]   m_err_addr;
   int            n_tests, n_fail;

   io_port_router dut (
      .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
      .memWR(memWR), .memRD(memRD), .READY(READY), .BUS_ERR(BUS_ERR),
      .slot_addr(slot_addr), .slot_wdata(slot_wdata), .slot_wr(slot_wr), .slot_rd(slot_rd),
      .slot_rdata(slot_rdata), .slot_ready(slot_ready), .irq_in(irq_in), .irq(irq)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always_comb begin
      slot_rdata = '0;
      for (int s = 0; s < NS; s++) slot_rdata[s*16 +: 16] = m_rdata[s];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU access; delay = cycles slot_ready stays low. ev = irq edges landing on the completion cycle.
   // Entered and left just after a rising edge.
   task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                         input logic [15:0] wdata, input int delay, input logic [7:0] ev);
      int          sel, exp_cyc;
      bit          mapped, ctrl, exp_err, done;
      logic [7:0]  stb, stb_c;
      logic [15:0] exp_data, fresh;
      sel     = int'(addr[15:12]);
      mapped  = sel < NS;
      ctrl    = sel == CTRL;
      exp_err = mapped && delay > TO;
      exp_cyc = !mapped ? 0 : (exp_err ? TO + 1 : delay);
      stb     = mapped ? 8'(1 << sel) : 8'h00;
      if (ctrl) begin
         case (addr[1:0])
            2'd0:    exp_data = {8'h00, m_pend};
            2'd1:    exp_data = {8'h00, m_mask};
            2'd2:    exp_data = {15'h0, m_err};
            default: exp_data = m_err_addr;
         endcase
      end else if (mapped && !exp_err) exp_data = m_rdata[sel];
      else exp_data = 16'h0000;

      ADDRESS = addr; DATA_IN = wdata; memWR = wr; memRD = rd;
      done = 1'b0;
      for (int c = 0; c <= TO + 2 && !done; c++) begin
         if (c > 0) begin @(posedge CLK); #1; end
         slot_ready = (mapped && c >= delay) ? stb : 8'h00;
         @(negedge CLK);
         stb_c = (c < exp_cyc || (c == exp_cyc && !exp_err)) ? stb : 8'h00;
         if (c == 0) begin
            chk("slot_addr", slot_addr, addr[11:0]);
            chk("slot_wdata", slot_wdata, wdata);
         end
         chk("slot_wr", slot_wr, wr ? stb_c : 8'h00);
         chk("slot_rd", slot_rd, (rd && !wr) ? stb_c : 8'h00);
         chk("ready", READY, c == exp_cyc);
         chk("bus_err", BUS_ERR, exp_err && c == exp_cyc);
         done = READY;
      end
      @(posedge CLK); #1;
      memWR = 0; memRD = 0; slot_ready = 0;

      if (exp_err) begin m_err = 1'b1; m_err_addr = addr; end
      if (ctrl && wr) begin
         case (addr[1:0])
            2'd0:    m_pend = m_pend & ~wdata[7:0];
            2'd1:    m_mask = wdata[7:0];
            2'd2:    if (wdata[0]) m_err = 1'b0;
            default: ;
         endcase
      end
      m_pend = m_pend | ev;
      // Disturb the slot's data after completion: only a late slot may follow it.
      if (rd && !wr && mapped) begin
         fresh = 16'($urandom);
         m_rdata[sel] = fresh;
         if (!exp_err && LATE[sel]) exp_data = fresh;
      end
      @(negedge CLK);
      if (rd && !wr) chk("data_out", DATA_OUT, exp_data);
      chk("irq", irq, |(m_pend & m_mask));
      @(posedge CLK); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] addr;
      int          sel, dly, kind;
      bit          wr, rd;
      n_tests = 0; n_fail = 0;
      m_pend = 0; m_mask = 0; m_err = 0; m_err_addr = 0;
      for (int s = 0; s < NS; s++) m_rdata[s] = 16'($urandom);
      irq_in = 0; DATA_IN = 0;
      // Reset with a ready request present: nothing may complete.
      RSTb = 0; ADDRESS = 16'h0000; memRD = 1; memWR = 0; slot_ready = 8'h01;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", READY, 1'b0);
      chk("rst_bus_err", BUS_ERR, 1'b0);
      chk("rst_slot_rd", slot_rd, 8'h00);
      chk("rst_slot_wr", slot_wr, 8'h00);
      chk("rst_data_out", DATA_OUT, 16'h0000);
      chk("rst_irq", irq, 1'b0);
      @(posedge CLK); #1;
      memRD = 0; slot_ready = 0; RSTb = 1;
      @(posedge CLK); #1;

      m_rdata[1] = 16'hBEEF;
      access(0, 1, 16'h1004, 16'h0000, 0, 8'h00);
      access(1, 0, 16'h4123, 16'h5A5A, 3, 8'h00);
      access(0, 1, 16'h3ABC, 16'h0000, 100, 8'h00);
      access(0, 1, 16'hA003, 16'h0000, 0, 8'h00);
      access(0, 1, 16'hA002, 16'h0000, 0, 8'h00);
      access(1, 0, 16'hA002, 16'h0001, 0, 8'h00);
      access(0, 1, 16'hA002, 16'h0000, 0, 8'h00);
      access(0, 1, 16'h5010, 16'h0000, 0, 8'h00);
      access(0, 1, 16'h5010, 16'h0000, 2, 8'h00);
      access(0, 1, 16'h6000, 16'h0000, TO, 8'h00);
      access(1, 0, 16'h7000, 16'h1111, TO + 1, 8'h00);
      access(0, 1, 16'h9000, 16'h0000, 0, 8'h00);
      access(1, 1, 16'h0010, 16'hC0DE, 1, 8'h00);

      // Interrupts: edge sets pending, and a set beats a same-cycle clear.
      access(1, 0, 16'hA001, 16'h0004, 0, 8'h00);
      irq_in = 8'h04;
      @(posedge CLK); #1;
      m_pend = m_pend | 8'h04;
      @(negedge CLK);
      chk("irq_edge", irq, 1'b1);
      @(posedge CLK); #1;
      access(0, 1, 16'hA000, 16'h0000, 0, 8'h00);
      irq_in = 8'h00;
      @(posedge CLK); #1;
      irq_in = 8'h04;
      access(1, 0, 16'hA000, 16'h0004, 0, 8'h04);
      access(0, 1, 16'hA000, 16'h0000, 0, 8'h00);
      access(1, 0, 16'hA000, 16'h0004, 0, 8'h00);

      // Randomized traffic; irq_in held steady so no new edges appear.
      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 6)       sel = int'($urandom_range(0, NS - 1));
         else if (kind < 8)  sel = CTRL;
         else begin
            sel = int'($urandom_range(8, 15));
            if (sel == CTRL) sel = 9;
         end
         addr = {4'(sel), 12'($urandom)};
         wr   = 1'($urandom);
         rd   = wr ? 1'($urandom) : 1'b1;
         case ($urandom_range(0, 5))
            0:       dly = TO;
            1:       dly = TO + 1 + int'($urandom_range(0, 3));
            default: dly = int'($urandom_range(0, 3));
         endcase
         access(wr, rd, addr, 16'($urandom), dly, 8'h00);
      end

      // Reset in the middle of a waiting access.
      irq_in = 8'h00;
      @(posedge CLK); #1;
      access(1, 0, 16'hA002, 16'h0001, 0, 8'h00);
      ADDRESS = 16'h2000; memRD = 1; slot_ready = 0;
      repeat (2) begin @(posedge CLK); #1; end
      RSTb = 0;
      @(negedge CLK);
      chk("midwait_ready", READY, 1'b0);
      chk("midwait_slot_rd", slot_rd, 8'h00);
      @(posedge CLK); #1;
      RSTb = 1; memRD = 0;
      m_pend = 0; m_mask = 0; m_err = 0; m_err_addr = 0;
      repeat (TO + 3) @(posedge CLK);
      #1;
      access(0, 1, 16'hA002, 16'h0000, 0, 8'h00);
      access(0, 1, 16'hA003, 16'h0000, 0, 8'h00);
      access(0, 1, 16'hA001, 16'h0000, 0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
